// File: rtl/block_plotter_if.sv
// Request channel into block_plotter: a block's top-left corner and colour
// carried over a valid/ready handshake.
interface block_plotter_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
);
   logic                req_valid;
   logic                req_ready;
   logic [X_W-1:0]      req_x;
   logic [Y_W-1:0]      req_y;
   logic [COLOUR_W-1:0] req_colour;

   modport master (
      output req_valid, req_x, req_y, req_colour,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_x, req_y, req_colour,
      output req_ready
   );
endinterface

// File: rtl/block_plotter.sv
// Buffers block-draw requests and expands each into BLOCK_SIZE^2 pixel writes.
// Define BLOCK_PLOTTER_CLIP_EN to suppress plot for off-screen pixels.
module block_plotter #(
   parameter int BLOCK_SIZE = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int COLOUR_W   = 3,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120
) (
   input  logic                clk,
   input  logic                reset,
   block_plotter_if.slave      req,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy
);

   localparam int LB = $clog2(BLOCK_SIZE);
   localparam int PW = 2 * LB;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = X_W + Y_W + COLOUR_W;

   localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [X_W:0]   SCR_W_C = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]   SCR_H_C = (Y_W + 1)'(SCREEN_H);

`ifdef BLOCK_PLOTTER_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAW
   } state_t;

   state_t state;

   logic [EW-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   logic [EW-1:0]       head;
   logic [X_W-1:0]      head_x;
   logic [Y_W-1:0]      head_y;
   logic [COLOUR_W-1:0] head_c;

   logic [X_W-1:0]      base_x;
   logic [Y_W-1:0]      base_y;
   logic [COLOUR_W-1:0] col;
   logic [PW-1:0]       p;
   logic [LB-1:0]       px;
   logic [LB-1:0]       py;
   logic [X_W:0]        x_sum;
   logic [Y_W:0]        y_sum;
   logic                on_screen;
   logic                more;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // Held low during reset so nothing is accepted into a FIFO being cleared.
   assign req.req_ready = !full && !reset;

   assign push = req.req_valid && req.req_ready;
   assign pop  = (state == LOAD);

   assign head   = mem[rd_ptr];
   assign head_x = head[EW-1 -: X_W];
   assign head_y = head[COLOUR_W +: Y_W];
   assign head_c = head[COLOUR_W-1:0];

   assign busy = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {req.req_x, req.req_y, req.req_colour};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   assign px = p[LB-1:0];
   assign py = p[PW-1:LB];

   // One bit wider than the outputs so the clip test sees the unwrapped sum.
   assign x_sum = {1'b0, base_x} + (X_W + 1)'(px);
   assign y_sum = {1'b0, base_y} + (Y_W + 1)'(py);

   assign on_screen = !CLIP || ((x_sum < SCR_W_C) && (y_sum < SCR_H_C));

   // DRAW never pops, so the post-edge count is empty-or-not plus this push.
   assign more = !empty || push;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         p      <= '0;
         base_x <= '0;
         base_y <= '0;
         col    <= '0;
         x_out  <= '0;
         y_out  <= '0;
         colour <= '0;
         plot   <= 1'b0;
      end else begin
         plot <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!empty)
                  state <= LOAD;
            end
            LOAD: begin
               base_x <= head_x;
               base_y <= head_y;
               col    <= head_c;
               p      <= '0;
               state  <= DRAW;
            end
            DRAW: begin
               x_out  <= x_sum[X_W-1:0];
               y_out  <= y_sum[Y_W-1:0];
               colour <= col;
               plot   <= on_screen;
               p      <= p + PW'(1);
               if (&p)
                  state <= more ? LOAD : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_plotter.sv
// Directed bench for block_plotter: table of single blocks plus
// back-to-back, full-FIFO, reset-abort and push-during-pop sequences.
module tb_block_plotter;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       plot;
   logic       busy;

   block_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) ifc ();

   block_plotter dut (
      .clk    (clk),
      .reset  (reset),
      .req    (ifc),
      .x_out  (x_out),
      .y_out  (y_out),
      .colour (colour),
      .plot   (plot),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         t;
   } pix_t;

   pix_t log_q[$];
   pix_t exp_q[$];

   // Outputs are registered on posedge; the falling edge sees them settled.
   always @(negedge clk) begin
      pix_t e;
      if (plot === 1'b1) begin
         e.x = x_out;
         e.y = y_out;
         e.c = colour;
         e.t = cyc;
         log_q.push_back(e);
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   function automatic void add_block(input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] c);
      for (int i = 0; i < 16; i++) begin
         logic [8:0] xs;
         logic [7:0] ys;
         pix_t       e;
         xs = {1'b0, x} + 9'(i % 4);
         ys = {1'b0, y} + 8'(i / 4);
`ifdef BLOCK_PLOTTER_CLIP_EN
         if (xs >= 9'd160 || ys >= 8'd120)
            continue;
`endif
         e.x = xs[7:0];
         e.y = ys[6:0];
         e.c = c;
         e.t = 0;
         exp_q.push_back(e);
      end
   endfunction

   task automatic compare_log(input string name);
      check({name, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (log_q[i].x !== exp_q[i].x || log_q[i].y !== exp_q[i].y ||
             log_q[i].c !== exp_q[i].c) begin
            n_err++;
            $display("FAIL %s pix%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     name, i, log_q[i].x, log_q[i].y, log_q[i].c,
                     exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      log_q.delete();
      exp_q.delete();
   endtask

   // Drives one request and returns the accept cycle and the edges it took.
   task automatic send(input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, output int acc, output int tries);
      logic r;
      acc   = -1;
      tries = 0;
      ifc.req_x      = x;
      ifc.req_y      = y;
      ifc.req_colour = c;
      ifc.req_valid  = 1'b1;
      for (int n = 0; n < 200; n++) begin
         r = ifc.req_ready;
         @(posedge clk);
         #1;
         tries++;
         if (r === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      ifc.req_valid = 1'b0;
      if (acc < 0)
         check("send accept timeout", 0, 1);
   endtask

   task automatic wait_idle(output int t);
      t = -1;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b0) begin
            t = cyc;
            break;
         end
      end
      if (t < 0)
         check("idle timeout", 0, 1);
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         n;
      int         span;
      int         lx;
      int         ly;
   } vec_t;

   vec_t tv[4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, acc2, acc3, tries, t_idle, stall;

`ifdef BLOCK_PLOTTER_CLIP_EN
      tv[0] = '{8'd80,  7'd60,  3'd1, 16, 15, 83,  63};
      tv[1] = '{8'd0,   7'd0,   3'd5, 16, 15, 3,   3};
      tv[2] = '{8'd158, 7'd118, 3'd7, 4,  5,  161, 121};
      tv[3] = '{8'd254, 7'd126, 3'd3, 0,  0,  1,   1};
`else
      tv[0] = '{8'd80,  7'd60,  3'd1, 16, 15, 83,  63};
      tv[1] = '{8'd0,   7'd0,   3'd5, 16, 15, 3,   3};
      tv[2] = '{8'd158, 7'd118, 3'd7, 16, 15, 161, 121};
      tv[3] = '{8'd254, 7'd126, 3'd3, 16, 15, 1,   1};
`endif

      ifc.req_valid  = 1'b0;
      ifc.req_x      = '0;
      ifc.req_y      = '0;
      ifc.req_colour = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst ready", ifc.req_ready, 0);
      check("rst plot", plot, 0);
      check("rst busy", busy, 0);
      check("rst x_out", x_out, 0);
      check("rst y_out", y_out, 0);
      check("rst colour", colour, 0);
      reset = 1'b0;
      #1;
      check("ready after rst", ifc.req_ready, 1);
      check("busy after rst", busy, 0);
      @(negedge clk);
      #1;
      log_q.delete();

      for (int i = 0; i < 4; i++) begin
         send(tv[i].x, tv[i].y, tv[i].c, acc, tries);
         wait_idle(t_idle);
         check($sformatf("vec%0d plots", i), 64'(log_q.size()), 64'(tv[i].n));
         check($sformatf("vec%0d busy fall", i), 64'(t_idle - acc), 18);
         check($sformatf("vec%0d x hold", i), x_out, 64'(tv[i].lx % 256));
         check($sformatf("vec%0d y hold", i), y_out, 64'(tv[i].ly % 128));
         if (log_q.size() > 0) begin
            check($sformatf("vec%0d latency", i), 64'(log_q[0].t - acc), 3);
            check($sformatf("vec%0d span", i),
                  64'(log_q[log_q.size()-1].t - log_q[0].t), 64'(tv[i].span));
         end
         add_block(tv[i].x, tv[i].y, tv[i].c);
         compare_log($sformatf("vec%0d", i));
      end

      send(8'd76, 7'd60, 3'd1, acc, tries);
      send(8'd56, 7'd60, 3'd0, acc2, tries);
      check("b2b accept gap", 64'(acc2 - acc), 1);
      wait_idle(t_idle);
      if (log_q.size() == 32) begin
         check("b2b latency", 64'(log_q[0].t - acc), 3);
         check("b2b span", 64'(log_q[31].t - log_q[0].t), 32);
         check("b2b load gap", 64'(log_q[16].t - log_q[15].t), 2);
      end
      add_block(8'd76, 7'd60, 3'd1);
      add_block(8'd56, 7'd60, 3'd0);
      compare_log("b2b");

      stall = -1;
      for (int i = 0; i < 12; i++) begin
         ifc.req_valid = 1'b1;
         send(8'(i * 8), 7'(i * 4), 3'(i), acc, tries);
         if (tries > 1 && stall < 0)
            stall = i;
         add_block(8'(i * 8), 7'(i * 4), 3'(i));
      end
      check("full accepted before stall", 64'(stall), 9);
      wait_idle(t_idle);
      compare_log("full");

      for (int i = 0; i < 4; i++)
         send(8'(20 + i * 4), 7'd40, 3'(i + 2), acc, tries);
      for (int n = 0; n < 100 && log_q.size() < 5; n++) begin
         @(negedge clk);
         #1;
      end
      check("rst-mid pixels before abort", 64'(log_q.size()), 5);
      reset = 1'b1;
      #1;
      check("rst-mid plot async", plot, 0);
      check("rst-mid busy", busy, 0);
      check("rst-mid ready", ifc.req_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst-mid ready after", ifc.req_ready, 1);
      check("rst-mid busy after", busy, 0);
      log_q.delete();
      repeat (40) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst-mid no plots", 64'(log_q.size()), 0);
      check("rst-mid still idle", busy, 0);

      send(8'd10, 7'd20, 3'd2, acc, tries);
      send(8'd30, 7'd20, 3'd3, acc2, tries);
      repeat (17) @(posedge clk);
      #1;
      send(8'd50, 7'd20, 3'd4, acc3, tries);
      check("pushpop accept edge", 64'(acc3 - acc), 19);
      check("pushpop first try", 64'(tries), 1);
      wait_idle(t_idle);
      if (log_q.size() == 48) begin
         check("pushpop gap AB", 64'(log_q[16].t - log_q[15].t), 2);
         check("pushpop gap BC", 64'(log_q[32].t - log_q[31].t), 2);
      end
      add_block(8'd10, 7'd20, 3'd2);
      add_block(8'd30, 7'd20, 3'd3);
      add_block(8'd50, 7'd20, 3'd4);
      compare_log("pushpop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
